// File: rtl/calculator_pkg.sv
// Shared definitions for the calculator button conditioner.
// Channel states, button indices and default timing constants.
package calculator_pkg;

    localparam int CLK_HZ  = 100_000_000;
    localparam int NUM_BTN = 5;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_C = 2;
    localparam int BTN_L = 3;
    localparam int BTN_R = 4;

    // 10 ms debounce, 0.5 s repeat delay, 0.1 s repeat period
    localparam int DEF_DEBOUNCE_CYCLES     = CLK_HZ / 100;
    localparam int DEF_REPEAT_DELAY_CYCLES = CLK_HZ / 2;
    localparam int DEF_REPEAT_RATE_CYCLES  = CLK_HZ / 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_HELD,
        ST_REPEAT,
        ST_DEB_RELEASE
    } btn_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/calculator_button_conditioner_if.sv
// Button bus between the board pins and the button consumers.
// The conditioner is the slave; the pin/consumer side is the master.
interface calculator_button_conditioner_if
    import calculator_pkg::*;
#(
    parameter int NUM_BUTTONS = NUM_BTN
);
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] repeat_en;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_repeat;
    logic [NUM_BUTTONS-1:0] btn_release;

    modport master (
        output btn_raw, repeat_en,
        input  btn_level, btn_press, btn_repeat, btn_release
    );

    modport slave (
        input  btn_raw, repeat_en,
        output btn_level, btn_press, btn_repeat, btn_release
    );
endinterface

// File: rtl/calculator_button_channel.sv
// One button: 2-flop synchronizer, debounce/repeat FSM, shared counter.
// All outputs are registered and change on the edge the FSM transitions.
module calculator_button_channel
    import calculator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic repeat_o,
    output logic release_o
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES,
                                    REPEAT_DELAY_CYCLES,
                                    REPEAT_RATE_CYCLES));

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE_CYCLES - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic          meta_q, sync_q;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rpt_q, rpt_d;
    logic          rel_q, rel_d;

    // Synchronizer, FSM state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rpt_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rpt_q   <= rpt_d;
            rel_q   <= rel_d;
        end
    end

    // Next state, counter update and pulse generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rpt_d   = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sync_q) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = ONE;
                end
            end
            ST_DEB_PRESS: begin
                if (!sync_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_HELD: begin
                if (!sync_q) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = ONE;
                end else if (cnt_q == DLY_LAST) begin
                    if (repeat_en_i) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                        press_d = 1'b1;
                        rpt_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_REPEAT: begin
                if (!sync_q) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = ONE;
                end else if (!repeat_en_i) begin
                    // Delay already served: re-enabling repeats at once
                    state_d = ST_HELD;
                    cnt_d   = DLY_LAST;
                end else if (cnt_q == RATE_LAST) begin
                    cnt_d   = '0;
                    press_d = 1'b1;
                    rpt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_DEB_RELEASE: begin
                if (sync_q) begin
                    // Bounce: stay pressed, restart the repeat delay
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == ST_HELD) ||
                  (state_d == ST_REPEAT) ||
                  (state_d == ST_DEB_RELEASE);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign repeat_o  = rpt_q;
    assign release_o = rel_q;

endmodule

// File: rtl/calculator_button_conditioner.sv
// Conditions the calculator push-buttons (U, D, C, L, R).
// One independent channel per button; this level only packs the buses.
module calculator_button_conditioner
    import calculator_pkg::*;
#(
    parameter int NUM_BUTTONS         = NUM_BTN,
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input logic                           clk,
    input logic                           rst,
    calculator_button_conditioner_if.slave bus
);

    logic [NUM_BUTTONS-1:0] level_w;
    logic [NUM_BUTTONS-1:0] press_w;
    logic [NUM_BUTTONS-1:0] rpt_w;
    logic [NUM_BUTTONS-1:0] rel_w;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        calculator_button_channel #(
            .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .raw_i      (bus.btn_raw[i]),
            .repeat_en_i(bus.repeat_en[i]),
            .level_o    (level_w[i]),
            .press_o    (press_w[i]),
            .repeat_o   (rpt_w[i]),
            .release_o  (rel_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_repeat  = rpt_w;
    assign bus.btn_release = rel_w;

endmodule

// File: tb/tb_calculator_button_conditioner.sv
// Bench for calculator_button_conditioner: directed scenarios and
// random traffic compared every cycle against a level/run-length model.
module tb_calculator_button_conditioner;

    localparam int NB   = 5;
    localparam int D    = 4;
    localparam int DLY  = 20;
    localparam int RATE = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    calculator_button_conditioner_if #(.NUM_BUTTONS(NB)) bus ();

    calculator_button_conditioner #(
        .NUM_BUTTONS        (NB),
        .DEBOUNCE_CYCLES    (D),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_RATE_CYCLES (RATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: accepted level plus run length of disagreeing
    // samples, and elapsed-time bookkeeping for the repeat schedule.
    bit d1[NB], d2[NB], lvl[NB], inrep[NB];
    int run[NB], el[NB], sr[NB];
    logic [NB-1:0] e_lvl, e_prs, e_rpt, e_rel;

    task automatic model(input logic [NB-1:0] raw,
                         input logic [NB-1:0] en, input logic r);
        bit s;
        e_prs = '0;
        e_rpt = '0;
        e_rel = '0;
        for (int i = 0; i < NB; i++) begin
            if (r) begin
                d1[i] = 0; d2[i] = 0; lvl[i] = 0; inrep[i] = 0;
                run[i] = 0; el[i] = 0; sr[i] = 0;
            end else begin
                s = d2[i];
                d2[i] = d1[i];
                d1[i] = raw[i];
                if (!lvl[i]) begin
                    if (s) begin
                        run[i]++;
                        if (run[i] == D) begin
                            lvl[i] = 1; run[i] = 0; e_prs[i] = 1;
                            el[i] = 0; inrep[i] = 0;
                        end
                    end else run[i] = 0;
                end else if (!s) begin
                    run[i]++;
                    inrep[i] = 0;
                    if (run[i] == D) begin
                        lvl[i] = 0; run[i] = 0; e_rel[i] = 1;
                    end
                end else if (run[i] > 0) begin
                    run[i] = 0; el[i] = 0; inrep[i] = 0;
                end else begin
                    if (el[i] < DLY) el[i]++;
                    if (inrep[i]) begin
                        if (!en[i]) inrep[i] = 0;
                        else begin
                            sr[i]++;
                            if (sr[i] == RATE) begin
                                sr[i] = 0; e_prs[i] = 1; e_rpt[i] = 1;
                            end
                        end
                    end else if (el[i] >= DLY && en[i]) begin
                        inrep[i] = 1; sr[i] = 0;
                        e_prs[i] = 1; e_rpt[i] = 1;
                    end
                end
            end
            e_lvl[i] = lvl[i];
        end
    endtask

    int rc;
    int pe[NB][$];
    int re[NB][$];

    task automatic rec_clear();
        rc = 0;
        for (int i = 0; i < NB; i++) begin
            pe[i].delete();
            re[i].delete();
        end
    endtask

    task automatic step(input logic [NB-1:0] raw,
                        input logic [NB-1:0] en, input logic r);
        bus.btn_raw   = raw;
        bus.repeat_en = en;
        rst           = r;
        @(posedge clk);
        #1;
        model(raw, en, r);
        rc++;
        check("level",   32'(bus.btn_level),   32'(e_lvl));
        check("press",   32'(bus.btn_press),   32'(e_prs));
        check("repeat",  32'(bus.btn_repeat),  32'(e_rpt));
        check("release", 32'(bus.btn_release), 32'(e_rel));
        for (int i = 0; i < NB; i++) begin
            if (bus.btn_press[i] === 1'b1) pe[i].push_back(rc);
            if (bus.btn_release[i] === 1'b1) re[i].push_back(rc);
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n, input logic [NB-1:0] raw,
                         input logic [NB-1:0] en);
        for (int k = 0; k < n; k++) step(raw, en, 1'b0);
    endtask

    logic [NB-1:0] rraw, ren;

    initial begin
        bus.btn_raw   = '0;
        bus.repeat_en = '0;
        rst           = 1'b1;
        @(negedge clk);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        steps(3, '0, '0);

        // 1: clean U press, no repeat
        rec_clear();
        steps(10, 5'b00001, '0);
        steps(12, '0, '0);
        check("s1_npress", 32'(pe[0].size()), 1);
        if (pe[0].size() > 0) check("s1_press_at", 32'(pe[0][0]), D + 2);
        check("s1_nrel", 32'(re[0].size()), 1);
        if (re[0].size() > 0) check("s1_rel_at", 32'(re[0][0]), 10 + D + 2);

        // 2: bouncing C, then held
        rec_clear();
        for (int b = 0; b < 2; b++) begin
            steps(2, 5'b00100, '0);
            steps(2, '0, '0);
        end
        steps(12, 5'b00100, '0);
        check("s2_npress", 32'(pe[2].size()), 1);
        if (pe[2].size() > 0) check("s2_press_at", 32'(pe[2][0]), 9 + D + 1);
        steps(12, '0, '0);

        // 3: D held 50 cycles with auto-repeat
        rec_clear();
        steps(50, 5'b00010, 5'b00010);
        steps(14, '0, 5'b00010);
        check("s3_npress", 32'(pe[1].size()), 5);
        for (int j = 0; j < 5 && j < pe[1].size(); j++)
            check("s3_press_at", 32'(pe[1][j]),
                  32'(D + 2 + (j > 0 ? DLY + (j - 1) * RATE : 0)));

        // 4: release glitch while held restarts the repeat delay
        rec_clear();
        steps(9, 5'b00010, 5'b00010);
        steps(2, '0, 5'b00010);
        steps(29, 5'b00010, 5'b00010);
        check("s4_nrel", 32'(re[1].size()), 0);
        check("s4_npress", 32'(pe[1].size()), 2);
        if (pe[1].size() > 1) check("s4_rpt_at", 32'(pe[1][1]), 12 + DLY + 2);
        steps(14, '0, '0);

        // 5: L and R together
        rec_clear();
        steps(10, 5'b11000, '0);
        steps(12, '0, '0);
        check("s5_l_at", pe[3].size() > 0 ? 32'(pe[3][0]) : 0, D + 2);
        check("s5_r_at", pe[4].size() > 0 ? 32'(pe[4][0]) : 0, D + 2);

        // 6: reset while U repeats, button still held
        rec_clear();
        steps(30, 5'b00001, 5'b00001);
        step(5'b00001, 5'b00001, 1'b1);
        check("s6_rst_lvl", 32'(bus.btn_level), 0);
        check("s6_nrel", 32'(re[0].size()), 0);
        rec_clear();
        steps(10, 5'b00001, 5'b00001);
        check("s6_press_at", pe[0].size() > 0 ? 32'(pe[0][0]) : 0, D + 2);
        check("s6_nrel2", 32'(re[0].size()), 0);
        steps(12, '0, '0);

        // Random traffic
        rraw = '0;
        ren  = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 29) == 0) rraw[i] = ~rraw[i];
                if ($urandom_range(0, 59) == 0) ren[i] = ~ren[i];
            end
            step(rraw, ren, $urandom_range(0, 699) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calculator_button_conditioner.md
# calculator_button_conditioner

Conditions the five raw push-buttons (U, D, C, L, R) of the calculator board before they reach the stage selector and seven-segment display logic. Each button is synchronized, debounced, and converted into a stable level, a one-cycle press pulse, and a one-cycle release pulse. Buttons can optionally auto-repeat while held, so the up/down buttons can scroll. It sits between the board pins and every consumer of `btnU/btnD/btnC/btnL/btnR` in the calculator top level.

## Interface
- `NUM_BUTTONS`, 5, number of independent button channels; index 0..4 = U, D, C, L, R.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive synchronized samples needed to accept a change (10 ms at 100 MHz); must be ≥ 2.
- `REPEAT_DELAY_CYCLES`, 50_000_000, hold time before the first auto-repeat; must be ≥ 2.
- `REPEAT_RATE_CYCLES`, 10_000_000, period between later auto-repeats; must be ≥ 2.
- `clk` in 1 — system clock; the only clock.
- `rst` in 1 — reset; synchronous, active-high.
- `btn_raw` in NUM_BUTTONS — asynchronous raw button pins.
- `repeat_en` in NUM_BUTTONS — per-button auto-repeat enable; synchronous to `clk`.
- `btn_level` out NUM_BUTTONS — debounced button state.
- `btn_press` out NUM_BUTTONS — one-cycle pulse on an accepted press and on each auto-repeat.
- `btn_repeat` out NUM_BUTTONS — high together with `btn_press` only when that pulse is an auto-repeat.
- `btn_release` out NUM_BUTTONS — one-cycle pulse on an accepted release.

## Operation
- Per channel: a 2-flop synchronizer produces `sync`, followed by a 5-state FSM and one shared down-time counter `cnt`.
- IDLE: `sync`=1 → DEB_PRESS, `cnt`←1.
- DEB_PRESS: `sync`=0 → IDLE, with no output. If `cnt`=DEBOUNCE_CYCLES−1 → HELD, `cnt`←0, `btn_level`←1, `btn_press` pulse. Otherwise `cnt`++.
- HELD: `sync`=0 → DEB_RELEASE, `cnt`←1.
  - Else if `repeat_en` and `cnt`=REPEAT_DELAY_CYCLES−1 → REPEAT, `cnt`←0, with `btn_press` and `btn_repeat` pulses.
  - Else `cnt`++, saturating at REPEAT_DELAY_CYCLES−1.
- REPEAT: `sync`=0 → DEB_RELEASE, `cnt`←1.
  - Else if `repeat_en`=0 → HELD, with `cnt` held saturated.
  - Else if `cnt`=REPEAT_RATE_CYCLES−1 → `cnt`←0, with `btn_press` and `btn_repeat` pulses.
  - Else `cnt`++.
- DEB_RELEASE: `sync`=1 → HELD, `cnt`←0. This is a bounce; there is no pulse and the repeat delay restarts.
  - If `cnt`=DEBOUNCE_CYCLES−1 → IDLE, `btn_level`←0, `btn_release` pulse.
  - Else `cnt`++.
- `btn_level` stays 1 throughout HELD, REPEAT and DEB_RELEASE. No repeat pulses are issued in DEB_RELEASE.
- All outputs are registered. The press and release pulses are exactly one cycle wide and never coincide on one channel.
- Channels are fully independent. Simultaneous presses on several buttons yield simultaneous pulses.
- `cnt` width is $clog2 of the largest of the three cycle parameters.

## Timing
- Reset: all FSMs → IDLE, `cnt`=0, synchronizer flops=0, and all outputs=0 from the cycle after `rst` is sampled high.
- Reset mid-operation drops a held button to released with no `btn_release` pulse. If the button is still held after reset, it is re-debounced and produces a fresh `btn_press`.
- Press latency: if `btn_raw` is first sampled high at edge 1 and stays high, `btn_press` is high for one cycle after edge DEBOUNCE_CYCLES+2. `btn_level` rises at the same edge.
- Release latency is symmetric: DEBOUNCE_CYCLES+2 edges.
- First repeat: REPEAT_DELAY_CYCLES edges after the accepted-press edge. Later repeats: every REPEAT_RATE_CYCLES edges.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no output change.
- Raising `repeat_en` in HELD after the delay has elapsed fires the repeat on the next edge.

## Structure
- Shared `calculator_pkg`:
  - channel state enum (IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE);
  - button index constants BTN_U=0 … BTN_R=4;
  - default timing constants derived from CLK_HZ=100_000_000.
- Sub-module `calculator_button_channel`: one synchronizer, FSM and counter, instantiated NUM_BUTTONS times in a generate loop. The top level only packs and unpacks the buses.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8.

1. Clean press of U held for 10 cycles, `repeat_en`=0 → `btn_press[0]` is a single pulse after edge 6 and `btn_level[0]`=1 from then on. Release gives `btn_release[0]` 6 edges after release, with no `btn_repeat`.
2. Raw C toggling 1-0-1-0 with 2-cycle pulses, then held → no output during the bounce. Exactly one `btn_press[2]`, 6 edges after the final rise.
3. D held 50 cycles with `repeat_en[1]`=1 → press at edge 6, then repeats at edges 26, 34, 42 and 50 (`btn_press`=`btn_repeat`=1). No repeat after release begins.
4. While held, a 2-cycle low glitch in DEB_RELEASE → `btn_level` stays 1, no release pulse, and the first repeat moves to 20 edges after the glitch ends plus 2.
5. L and R pressed on the same edge → identical, simultaneous `btn_press[3]` and `btn_press[4]` pulses.
6. `rst` asserted while U is in REPEAT with the raw input still high → all outputs 0 the next cycle, no `btn_release`. After reset deasserts, `btn_press[0]` reappears 6 edges later.
